// File: rtl/iopmp_scan_ctrl_pkg.sv
// Shared types for the sequential IOPMP checker: address-match modes, entry
// permissions and controller states.
package iopmp_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        TOR   = 2'b01,
        NA4   = 2'b10,
        NAPOT = 2'b11
    } iopmp_addr_mode_t;

    typedef struct packed {
        logic r;
        logic w;
    } iopmp_perm_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } iopmp_state_t;

    // An access that needs neither read nor write is allowed by any matching entry.
    function automatic logic perm_ok(iopmp_perm_t perm, logic rd, logic wr);
        return (!rd || perm.r) && (!wr || perm.w);
    endfunction

endpackage

// File: rtl/iopmp_scan_ctrl_if.sv
// Request/verdict handshake between a bus requester and the IOPMP checker.
interface iopmp_scan_ctrl_if #(
    parameter int unsigned PLEN        = 56,
    parameter int unsigned NUM_ENTRIES = 8
);
    localparam int unsigned IW = $clog2(NUM_ENTRIES);

    logic            req_valid;
    logic            req_ready;
    logic [PLEN-1:0] req_addr;
    logic            req_read;
    logic            req_write;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_allow;
    logic            rsp_hit;
    logic [IW-1:0]   rsp_idx;

    modport master (
        output req_valid, req_addr, req_read, req_write, rsp_ready,
        input  req_ready, rsp_valid, rsp_allow, rsp_hit, rsp_idx
    );

    modport slave (
        input  req_valid, req_addr, req_read, req_write, rsp_ready,
        output req_ready, rsp_valid, rsp_allow, rsp_hit, rsp_idx
    );
endinterface

// File: rtl/iopmp_scan_ctrl_pmp_entry.sv
// Single PMP-style region matcher: OFF, TOR, NA4 and NAPOT address modes.
module pmp_entry
    import iopmp_pkg::*;
#(
    parameter int unsigned PLEN    = 56,
    parameter int unsigned PMP_LEN = 54
) (
    input  logic [PLEN-1:0]    addr_i,
    input  logic [PMP_LEN-1:0] conf_addr_i,
    input  logic [PMP_LEN-1:0] conf_addr_prev_i,
    input  iopmp_addr_mode_t   conf_addr_mode_i,
    output logic               match_o
);
    // Compare in a width that holds both the request and a shifted entry address.
    localparam int unsigned W = (PLEN > PMP_LEN + 2) ? PLEN : PMP_LEN + 2;

    logic [W-1:0] addr_w;
    logic [W-1:0] base_w;
    logic [W-1:0] prev_w;
    logic [W-1:0] mask_w;
    logic         run;
    int           size;

    always_comb begin
        addr_w = W'(addr_i);
        base_w = W'({conf_addr_i, 2'b00});
        prev_w = W'({conf_addr_prev_i, 2'b00});
        run    = 1'b1;
        size   = 2;
        if (conf_addr_mode_i == NAPOT) begin
            size = 3;
            for (int i = 0; i < int'(PMP_LEN); i++) begin
                if (run && conf_addr_i[i]) begin
                    size = size + 1;
                end else begin
                    run = 1'b0;
                end
            end
        end
        for (int i = 0; i < int'(W); i++) begin
            mask_w[i] = (i >= size);
        end
        unique case (conf_addr_mode_i)
            TOR:        match_o = (addr_w >= prev_w) && (addr_w < base_w);
            NA4, NAPOT: match_o = ((addr_w ^ base_w) & mask_w) == '0;
            default:    match_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/iopmp_scan_ctrl.sv
// Sequential IOPMP checker: walks NUM_ENTRIES regions lowest index first through
// one shared pmp_entry matcher; the first matching entry decides the verdict.
module iopmp_scan_ctrl
    import iopmp_pkg::*;
#(
    parameter int unsigned PLEN          = 56,
    parameter int unsigned PMP_LEN       = 54,
    parameter int unsigned NUM_ENTRIES   = 8,
    parameter logic        DEFAULT_ALLOW = 1'b0,
    localparam int unsigned IW           = $clog2(NUM_ENTRIES)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    iopmp_scan_ctrl_if.slave   bus,
    input  logic               cfg_we_i,
    output logic               cfg_ready_o,
    input  logic [IW-1:0]      cfg_idx_i,
    input  logic [PMP_LEN-1:0] cfg_addr_i,
    input  iopmp_addr_mode_t   cfg_mode_i,
    input  iopmp_perm_t        cfg_perm_i
);
    iopmp_state_t       state_q, state_d;
    logic [IW-1:0]      scan_idx_q, scan_idx_d;
    logic [PLEN-1:0]    lat_addr_q, lat_addr_d;
    logic               lat_rd_q, lat_rd_d;
    logic               lat_wr_q, lat_wr_d;
    logic               req_ready_q, req_ready_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_allow_q, rsp_allow_d;
    logic               rsp_hit_q, rsp_hit_d;
    logic [IW-1:0]      rsp_idx_q, rsp_idx_d;

    iopmp_addr_mode_t   ent_mode_q [NUM_ENTRIES];
    iopmp_addr_mode_t   ent_mode_d [NUM_ENTRIES];
    logic [PMP_LEN-1:0] ent_addr_q [NUM_ENTRIES];
    logic [PMP_LEN-1:0] ent_addr_d [NUM_ENTRIES];
    iopmp_perm_t        ent_perm_q [NUM_ENTRIES];
    iopmp_perm_t        ent_perm_d [NUM_ENTRIES];

    logic               idx_ok;
    logic               cfg_wr_en;
    logic [PMP_LEN-1:0] prev_addr;
    logic               match;

    if ((1 << IW) == NUM_ENTRIES) begin : g_idx_full
        assign idx_ok = 1'b1;
    end else begin : g_idx_part
        assign idx_ok = (32'(cfg_idx_i) < NUM_ENTRIES);
    end

    // Writes land in IDLE only, so a request accepted on the same edge scans the new value.
    always_comb begin
        ent_mode_d = ent_mode_q;
        ent_addr_d = ent_addr_q;
        ent_perm_d = ent_perm_q;
        cfg_wr_en  = cfg_we_i && cfg_ready_q && idx_ok;
        if (cfg_wr_en) begin
            ent_mode_d[cfg_idx_i] = cfg_mode_i;
            ent_addr_d[cfg_idx_i] = cfg_addr_i;
            ent_perm_d[cfg_idx_i] = cfg_perm_i;
        end
    end

    // TOR lower bound is the previous entry's address whatever that entry's mode.
    assign prev_addr = (scan_idx_q == '0) ? '0 : ent_addr_q[scan_idx_q - IW'(1)];

    pmp_entry #(
        .PLEN    (PLEN),
        .PMP_LEN (PMP_LEN)
    ) u_pmp_entry (
        .addr_i           (lat_addr_q),
        .conf_addr_i      (ent_addr_q[scan_idx_q]),
        .conf_addr_prev_i (prev_addr),
        .conf_addr_mode_i (ent_mode_q[scan_idx_q]),
        .match_o          (match)
    );

    always_comb begin
        state_d     = state_q;
        scan_idx_d  = scan_idx_q;
        lat_addr_d  = lat_addr_q;
        lat_rd_d    = lat_rd_q;
        lat_wr_d    = lat_wr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_allow_d = rsp_allow_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_idx_d   = rsp_idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d    = SCAN;
                    scan_idx_d = '0;
                    lat_addr_d = bus.req_addr;
                    lat_rd_d   = bus.req_read;
                    lat_wr_d   = bus.req_write;
                end
            end
            SCAN: begin
                if (match) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_hit_d   = 1'b1;
                    rsp_idx_d   = scan_idx_q;
                    rsp_allow_d = perm_ok(ent_perm_q[scan_idx_q], lat_rd_q, lat_wr_q);
                end else if (scan_idx_q == IW'(NUM_ENTRIES - 1)) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_hit_d   = 1'b0;
                    rsp_idx_d   = '0;
                    rsp_allow_d = DEFAULT_ALLOW;
                end else begin
                    scan_idx_d = scan_idx_q + IW'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_allow_d = 1'b0;
                    rsp_hit_d   = 1'b0;
                    rsp_idx_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
        cfg_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            scan_idx_q  <= '0;
            lat_addr_q  <= '0;
            lat_rd_q    <= 1'b0;
            lat_wr_q    <= 1'b0;
            req_ready_q <= 1'b1;
            cfg_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_allow_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
            for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
                ent_mode_q[i] <= OFF;
                ent_addr_q[i] <= '0;
                ent_perm_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            scan_idx_q  <= scan_idx_d;
            lat_addr_q  <= lat_addr_d;
            lat_rd_q    <= lat_rd_d;
            lat_wr_q    <= lat_wr_d;
            req_ready_q <= req_ready_d;
            cfg_ready_q <= cfg_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_allow_q <= rsp_allow_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_idx_q   <= rsp_idx_d;
            ent_mode_q  <= ent_mode_d;
            ent_addr_q  <= ent_addr_d;
            ent_perm_q  <= ent_perm_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_allow = rsp_allow_q;
    assign bus.rsp_hit   = rsp_hit_q;
    assign bus.rsp_idx   = rsp_idx_q;
    assign cfg_ready_o   = cfg_ready_q;
endmodule

// File: tb/tb_iopmp_scan_ctrl.sv
// Bench for iopmp_scan_ctrl: fixed vector table, hand-written corner sequences and
// randomized configurations checked against a region-range model.
module tb_iopmp_scan_ctrl;
    import iopmp_pkg::*;

    localparam int unsigned PLEN    = 56;
    localparam int unsigned PMP_LEN = 54;
    localparam int unsigned NE      = 8;
    localparam int unsigned IW      = 3;
    localparam logic        DEF_ALLOW = 1'b0;
    localparam iopmp_perm_t P_NONE = 2'b00;
    localparam iopmp_perm_t P_R    = 2'b10;
    localparam iopmp_perm_t P_RW   = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iopmp_scan_ctrl_if #(.PLEN(PLEN), .NUM_ENTRIES(NE)) bus_if ();

    logic               cfg_we;
    logic               cfg_ready;
    logic [IW-1:0]      cfg_idx;
    logic [PMP_LEN-1:0] cfg_addr;
    iopmp_addr_mode_t   cfg_mode;
    iopmp_perm_t        cfg_perm;

    iopmp_scan_ctrl #(
        .PLEN(PLEN), .PMP_LEN(PMP_LEN), .NUM_ENTRIES(NE), .DEFAULT_ALLOW(DEF_ALLOW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_if),
        .cfg_we_i(cfg_we), .cfg_ready_o(cfg_ready), .cfg_idx_i(cfg_idx),
        .cfg_addr_i(cfg_addr), .cfg_mode_i(cfg_mode), .cfg_perm_i(cfg_perm)
    );

    int checks = 0;
    int errors = 0;

    iopmp_addr_mode_t m_mode [NE];
    logic [63:0]      m_addr [NE];
    iopmp_perm_t      m_perm [NE];

    typedef struct {
        logic [63:0] addr;
        logic        rd;
        logic        wr;
        logic        hit;
        int          idx;
        logic        allow;
        int          lat;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int k = 0; k < int'(NE); k++) begin
            m_mode[k] = OFF;
            m_addr[k] = '0;
            m_perm[k] = P_NONE;
        end
    endfunction

    // Each entry is turned into a byte range [lo, hi); first range containing the address wins.
    function automatic void model_eval(input logic [63:0] a, input logic rd, input logic wr,
                                       output logic hit, output int idx, output logic allow);
        hit = 1'b0;
        idx = 0;
        allow = DEF_ALLOW;
        for (int k = 0; k < int'(NE); k++) begin
            logic [63:0] lo;
            logic [63:0] hi;
            logic [63:0] sz;
            int t;
            lo = '0;
            hi = '0;
            case (m_mode[k])
                TOR: begin
                    if (k > 0) lo = m_addr[k-1] * 4;
                    hi = m_addr[k] * 4;
                end
                NA4: begin
                    lo = m_addr[k] * 4;
                    hi = lo + 4;
                end
                NAPOT: begin
                    t = 0;
                    while (t < int'(PMP_LEN) && m_addr[k][t]) t++;
                    sz = 64'd1 << (t + 3);
                    lo = m_addr[k] * 4 - (sz / 2 - 4);
                    hi = lo + sz;
                end
                default: ;
            endcase
            if (m_mode[k] != OFF && a >= lo && a < hi) begin
                hit = 1'b1;
                idx = k;
                allow = (!rd || m_perm[k].r) && (!wr || m_perm[k].w);
                return;
            end
        end
    endfunction

    task automatic cfg_write(input int idx, input iopmp_addr_mode_t mode,
                             input logic [63:0] addr, input iopmp_perm_t perm);
        cfg_we   = 1'b1;
        cfg_idx  = IW'(idx);
        cfg_mode = mode;
        cfg_addr = addr[PMP_LEN-1:0];
        cfg_perm = perm;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_mode[idx] = mode;
        m_addr[idx] = addr;
        m_perm[idx] = perm;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!bus_if.rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus_if.rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: rsp_valid still low after %0d cycles, expected high", lat);
        end
    endtask

    task automatic start_req(input logic [63:0] a, input logic rd, input logic wr);
        bus_if.req_addr  = a[PLEN-1:0];
        bus_if.req_read  = rd;
        bus_if.req_write = wr;
        bus_if.req_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
    endtask

    task automatic check_req(input string name, input logic [63:0] a, input logic rd, input logic wr,
                             input logic e_hit, input int e_idx, input logic e_allow, input int e_lat);
        int lat;
        check({name, ".req_ready"}, bus_if.req_ready, 1);
        start_req(a, rd, wr);
        wait_rsp(lat);
        check({name, ".lat"}, lat, e_lat);
        check({name, ".hit"}, bus_if.rsp_hit, e_hit);
        check({name, ".idx"}, bus_if.rsp_idx, e_idx);
        check({name, ".allow"}, bus_if.rsp_allow, e_allow);
        bus_if.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.rsp_ready = 1'b0;
    endtask

    task automatic check_reset_outs(input string name);
        check({name, ".req_ready"}, bus_if.req_ready, 1);
        check({name, ".cfg_ready"}, cfg_ready, 1);
        check({name, ".rsp_valid"}, bus_if.rsp_valid, 0);
        check({name, ".rsp_allow"}, bus_if.rsp_allow, 0);
        check({name, ".rsp_hit"}, bus_if.rsp_hit, 0);
        check({name, ".rsp_idx"}, bus_if.rsp_idx, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic e_hit;
        int e_idx;
        logic e_allow;

        bus_if.req_valid = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_read  = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.rsp_ready = 1'b0;
        cfg_we   = 1'b0;
        cfg_idx  = '0;
        cfg_addr = '0;
        cfg_mode = OFF;
        cfg_perm = P_NONE;
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a scan.
        cfg_write(0, NA4, 64'h0, P_RW);
        start_req(64'h400, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("mid_scan.req_ready_busy", bus_if.req_ready, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outs("rst_scan");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        model_clear();

        // Asynchronous reset while a verdict is being held.
        cfg_write(0, NA4, 64'h0, P_RW);
        start_req(64'h0, 1'b1, 1'b0);
        wait_rsp(lat);
        check("mid_resp.lat", lat, 1);
        check("mid_resp.allow", bus_if.rsp_allow, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outs("rst_resp");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        model_clear();
        check_req("post_reset", 64'h0, 1'b1, 1'b0, 1'b0, 0, DEF_ALLOW, NE);

        // Vector table against a fixed TOR/NAPOT configuration.
        cfg_write(0, OFF, 64'h400, P_NONE);
        cfg_write(1, TOR, 64'h800, P_R);
        cfg_write(2, NAPOT, 64'h4000_03FF, P_R);
        vecs[0] = '{64'h1800,        1'b0, 1'b1, 1'b1, 1, 1'b0, 2};
        vecs[1] = '{64'h1800,        1'b1, 1'b0, 1'b1, 1, 1'b1, 2};
        vecs[2] = '{64'h1_0000_1000, 1'b1, 1'b0, 1'b1, 2, 1'b1, 3};
        vecs[3] = '{64'h1_0000_2000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8};
        vecs[4] = '{64'h1_0000_0000, 1'b0, 1'b1, 1'b1, 2, 1'b0, 3};
        vecs[5] = '{64'h0FFC,        1'b1, 1'b0, 1'b0, 0, 1'b0, 8};
        vecs[6] = '{64'h1000,        1'b1, 1'b0, 1'b1, 1, 1'b1, 2};
        vecs[7] = '{64'h1FFF,        1'b1, 1'b1, 1'b1, 1, 1'b0, 2};
        vecs[8] = '{64'h2000,        1'b1, 1'b0, 1'b0, 0, 1'b0, 8};
        vecs[9] = '{64'h1_0000_1FFF, 1'b0, 1'b0, 1'b1, 2, 1'b1, 3};
        for (int i = 0; i < 10; i++) begin
            check_req($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rd, vecs[i].wr,
                      vecs[i].hit, vecs[i].idx, vecs[i].allow, vecs[i].lat);
        end

        // Priority: lower index wins even when it denies.
        cfg_write(0, NA4, 64'h400, P_NONE);
        cfg_write(1, NAPOT, 64'h5FF, P_RW);
        check_req("prio_na4", 64'h1000, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1);
        check_req("prio_napot", 64'h1004, 1'b1, 1'b0, 1'b1, 1, 1'b1, 2);
        check_req("prio_napot_top", 64'h1FFC, 1'b0, 1'b1, 1'b1, 1, 1'b1, 2);

        // Backpressure: verdict held, config writes locked out.
        start_req(64'h1000, 1'b1, 1'b0);
        wait_rsp(lat);
        check("bp.lat", lat, 1);
        cfg_we   = 1'b1;
        cfg_idx  = '0;
        cfg_mode = OFF;
        cfg_addr = '0;
        cfg_perm = P_RW;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp%0d.rsp_valid", c), bus_if.rsp_valid, 1);
            check($sformatf("bp%0d.hit", c), bus_if.rsp_hit, 1);
            check($sformatf("bp%0d.allow", c), bus_if.rsp_allow, 0);
            check($sformatf("bp%0d.cfg_ready", c), cfg_ready, 0);
            check($sformatf("bp%0d.req_ready", c), bus_if.req_ready, 0);
        end
        cfg_we = 1'b0;
        bus_if.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.rsp_ready = 1'b0;
        check("bp_done.req_ready", bus_if.req_ready, 1);
        check("bp_done.cfg_ready", cfg_ready, 1);
        check("bp_done.rsp_valid", bus_if.rsp_valid, 0);
        check_req("bp_cfg_ignored", 64'h1000, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1);

        // Config write and request accepted on the same edge: scan sees the new entry.
        cfg_we   = 1'b1;
        cfg_idx  = '0;
        cfg_mode = NA4;
        cfg_addr = 54'h400;
        cfg_perm = P_R;
        bus_if.req_addr  = 56'h1000;
        bus_if.req_read  = 1'b1;
        bus_if.req_write = 1'b0;
        bus_if.req_valid = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        bus_if.req_valid = 1'b0;
        m_perm[0] = P_R;
        wait_rsp(lat);
        check("collide.lat", lat, 1);
        check("collide.hit", bus_if.rsp_hit, 1);
        check("collide.idx", bus_if.rsp_idx, 0);
        check("collide.allow", bus_if.rsp_allow, 1);
        bus_if.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.rsp_ready = 1'b0;

        // Randomized configurations against the range model.
        for (int round = 0; round < 20; round++) begin
            for (int k = 0; k < int'(NE); k++) begin
                iopmp_addr_mode_t md;
                logic [63:0] ea;
                int t;
                md = iopmp_addr_mode_t'($urandom_range(0, 3));
                ea = 64'($urandom_range(0, 'h7FF));
                if (md == NAPOT) begin
                    t = $urandom_range(0, 6);
                    ea = ((ea >> (t + 1)) << (t + 1)) | ((64'd1 << t) - 1);
                end
                cfg_write(k, md, ea, iopmp_perm_t'($urandom_range(0, 3)));
            end
            for (int r = 0; r < 12; r++) begin
                logic [63:0] a;
                logic rd;
                logic wr;
                int pick;
                pick = $urandom_range(0, int'(NE) - 1);
                if ($urandom_range(0, 1) == 1)
                    a = m_addr[pick] * 4 + 64'($urandom_range(0, 15));
                else
                    a = 64'($urandom_range(0, 'h2100));
                rd = 1'($urandom_range(0, 1));
                wr = 1'($urandom_range(0, 1));
                model_eval(a, rd, wr, e_hit, e_idx, e_allow);
                check_req($sformatf("rnd%0d_%0d", round, r), a, rd, wr, e_hit, e_idx, e_allow,
                          e_hit ? e_idx + 1 : int'(NE));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/iopmp_scan_ctrl.md
Name: iopmp_scan_ctrl

Overview:
- Sequential IOPMP checker. Holds NUM_ENTRIES region configurations and walks them in priority order, lowest index first.
- A single shared pmp_entry matcher is time-multiplexed across entries, one entry per cycle. The first matching entry decides the access.
- Sits between a DMA/bus requester's address phase and the permission-fault logic. Trades latency for area against a fully parallel matcher array.

Parameters:
- PLEN, 56, physical address width of checked requests
- PMP_LEN, 54, width of stored entry addresses (address >> 2)
- NUM_ENTRIES, 8, number of configurable entries; must be ≥ 2
- DEFAULT_ALLOW, 1'b0, verdict when no entry matches

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  check request valid
- req_ready_o  out  1  controller can accept a request
- req_addr_i  in  PLEN  address to check
- req_read_i  in  1  access needs read permission
- req_write_i  in  1  access needs write permission
- rsp_valid_o  out  1  verdict valid
- rsp_ready_i  in  1  consumer accepts verdict
- rsp_allow_o  out  1  access permitted
- rsp_hit_o  out  1  some entry matched
- rsp_idx_o  out  $clog2(NUM_ENTRIES)  index of matching entry; 0 when no hit
- cfg_we_i  in  1  configuration write strobe
- cfg_ready_o  out  1  configuration write accepted this cycle
- cfg_idx_i  in  $clog2(NUM_ENTRIES)  entry to write
- cfg_addr_i  in  PMP_LEN  entry address
- cfg_mode_i  in  iopmp_addr_mode_t  OFF/TOR/NA4/NAPOT
- cfg_perm_i  in  iopmp_perm_t  {r, w}

Behaviour:
- Reset: state IDLE.
  - Outputs: req_ready_o=1, cfg_ready_o=1, rsp_valid_o=0, rsp_allow_o=0, rsp_hit_o=0, rsp_idx_o=0.
  - All entries: mode OFF, addr 0, perm 0.
- FSM states:
  - IDLE -> SCAN on req_valid_i && req_ready_o. Latch addr/read/write; scan index := 0.
  - SCAN, each cycle: pmp_entry evaluates entry[idx].
    - conf_addr_prev = entry[idx-1].addr, or 0 when idx=0. This holds regardless of the previous entry's mode.
    - On match: latch hit=1, idx, allow = (!rd || perm.r) && (!wr || perm.w); go to RESP.
    - If no match and idx = NUM_ENTRIES-1: latch hit=0, idx=0, allow=DEFAULT_ALLOW; go to RESP.
    - Otherwise idx+1.
  - RESP: rsp_valid_o=1. Outputs stay stable until rsp_ready_i. On handshake go to IDLE.
- Latency:
  - Match at entry k: rsp_valid_o rises k+1 cycles after the accept edge.
  - No match: NUM_ENTRIES cycles after the accept edge.
- Throughput: req_ready_o=1 only in IDLE. No overlap between requests; the minimum request-to-request period is 3 cycles.
- Request with req_read_i=0 and req_write_i=0: a matching entry allows it regardless of perm.
- Config port:
  - cfg_ready_o=1 only in IDLE.
  - A write takes effect at the clock edge where cfg_we_i && cfg_ready_o.
  - A write of cfg_idx_i ≥ NUM_ENTRIES is ignored.
  - A write and a request accepted in the same IDLE cycle: the config update completes first. The scan of that request uses the new value.
  - In SCAN or RESP, cfg_we_i is ignored (cfg_ready_o=0). The requester must hold the write.
- Matching rules are exactly those of pmp_entry: OFF never matches; TOR is [prev<<2, addr<<2); NA4 is a 4-byte region; NAPOT size follows trailing ones.
- Asynchronous reset mid-SCAN or mid-RESP: immediate return to the reset values above. The in-flight verdict is lost and configuration is cleared.
- Scan index counter is $clog2(NUM_ENTRIES) bits. It never wraps, because the scan terminates at NUM_ENTRIES-1.

Decomposition:
- iopmp_pkg holds:
  - iopmp_addr_mode_t and constants OFF=2'b00, TOR=2'b01, NA4=2'b10, NAPOT=2'b11.
  - iopmp_perm_t: packed struct {r, w}.
  - iopmp_state_t enum {IDLE, SCAN, RESP}.
- One sub-module: the existing pmp_entry, instantiated once, fed through a mux indexed by the scan index.
- Entry register file and FSM stay in iopmp_scan_ctrl.

Test Plan:
- Reset: drive rst_ni low mid-SCAN -> outputs return to reset values immediately. After release, a request to 0x0 gives hit=0, allow=DEFAULT_ALLOW after 8 cycles.
- TOR deny: entry0 {OFF, 0x400}, entry1 {TOR, 0x800, perm r}. Write request to 0x1800 -> hit=1, idx=1, allow=0, rsp_valid 2 cycles after accept.
- NAPOT allow: entry2 {NAPOT, 0x4000_03FF, r} (8 KiB at 0x1_0000_0000). Read 0x1_0000_1000 -> hit=1, idx=2, allow=1, latency 3. Read 0x1_0000_2000 -> hit=0, allow=0.
- Priority: entry0 NA4 {0x400, perm 0} and entry1 NAPOT covering 0x1000 with {r, w}. Read 0x1000 -> idx=0, allow=0.
- Backpressure and config lockout: hold rsp_ready_i=0 for 5 cycles -> verdict stable, cfg_ready_o=0, cfg_we_i to entry0 has no effect. After handshake, req_ready_o and cfg_ready_o return to 1.
- Config/request collision: in IDLE, write entry0 {NA4, 0x400, r} together with a read request to 0x1000 -> hit=1, idx=0, allow=1, latency 1.
